frame_sequencer: RTL
====================

Name: frame_sequencer

Overview:
Timing and frame-stepping stage that drives the per-animation frame-limit lookup and the segment pattern ROM.
- Owns the current animation index and emits it to the limit lookup.
- Takes back the frame limit for that animation.
- Steps a frame counter from a programmable prescaler, wrapping at the limit.
- Optional auto mode advances to the next animation after a set number of complete loops.

Parameters:
BASE_DIV, 10_000_000, prescaler divisor at speed=0 (clk cycles per frame)
PRESC_W, 24, prescaler counter width; must hold BASE_DIV-1
LOOPS, 3, complete loops per animation before auto-advance (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes all state except reset
animation_sel  input  6  requested animation in manual mode
limit  input  6  frame count of current animation, from limit lookup (combinational on animation)
speed  input  3  divisor = max(1, BASE_DIV >> speed)
auto_mode  input  1  1 = auto-advance through animations, 0 = follow animation_sel
pause  input  1  1 = hold current frame
animation  output  6  registered current animation index
frame  output  6  registered frame index, 0..limit-1
frame_tick  output  1  one-cycle pulse on each frame advance
loop_done  output  1  one-cycle pulse when frame wraps to 0

Behaviour:
- Reset (async, rst_n=0): animation=0, frame=0, prescaler=0, loop counter=0, frame_tick=0, loop_done=0, state=S_LOAD.
- ena=0: all registers hold; pulses forced 0.
- States:
  - S_LOAD: clear frame, prescaler and loop counter; next state S_HOLD if pause, else S_RUN. Exactly 1 cycle.
  - S_RUN: prescaler counts. When prescaler == divisor-1:
    - prescaler → 0; frame_tick=1 next cycle.
    - frame advances; if frame >= limit-1, frame → 0 and loop_done=1 (same cycle as frame_tick).
    - pause=1 → S_HOLD; prescaler and frame keep their values.
  - S_HOLD: everything frozen; pause=0 → S_RUN, resuming from the held prescaler value.
- Change detection (checked in S_RUN and S_HOLD):
  - Manual mode: animation_sel != animation → animation <= animation_sel, state → S_LOAD.
  - Auto mode: on a wrap with loop counter == LOOPS-1 → animation <= animation+1 (63 wraps to 0), state → S_LOAD. Otherwise the loop counter increments on each wrap.
  - A change takes priority over a simultaneous tick; that tick is dropped and no pulses are emitted.
  - Leaving auto mode with animation_sel != animation triggers a load on the next cycle.
- Limit handling:
  - limit is sampled only in S_RUN.
  - limit==0 is treated as 1: frame stays 0 and loop_done fires on every tick.
  - If limit drops below frame+1 (external change), the next tick wraps to 0.
- Divisor: shift of BASE_DIV, floored at 1 (at 1, a tick fires every cycle).
- frame, animation, frame_tick and loop_done are all registered; no combinational input-to-output paths.
- Latency:
  - New animation_sel is visible on animation 1 cycle later.
  - frame resets to 0 in that same cycle.
  - First tick comes divisor+1 cycles after the load cycle.

Decomposition:
- Shared package: state encoding (S_LOAD, S_RUN, S_HOLD), ANI_W=6, FRAME_W=6.
- One sub-module: tick_prescaler (counter, divisor compute, tick output, clear/hold inputs).

Test Plan:
- BASE_DIV=8, speed=0, manual sel=0, limit=10 → frame_tick every 8 cycles; frame 0..9 then 0 with loop_done on the wrap; both pulses exactly 1 cycle.
- speed=3 (divisor 1), limit=2 → frame toggles 0,1,0,1 every cycle; loop_done on every second tick.
- Mid-run sel 0→1, with limit switching 10→12 → animation=1 the next cycle, frame=0, no pulse in the load cycle, first tick 9 cycles later; a tick arriving in the same cycle as the change is suppressed.
- pause held 20 cycles at frame=4 → frame stays 4, no ticks; on release, the first tick arrives after the remaining prescaler count.
- auto_mode=1, LOOPS=3, animation=63, limit=2 → after 3 wraps animation becomes 0 and frame=0; assert rst_n=0 mid-count → all outputs 0 immediately, without waiting for a clock edge.
- limit=0 → frame stays 0 and loop_done fires on every tick; ena=0 for 10 cycles → frame, animation and prescaler unchanged.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// frame_sequencer_pkg
// Shared definitions for the frame sequencer slice: the widths of the animation
// and frame indices, the sequencer state encoding and a small helper that maps
// a raw frame limit onto the value actually used for wrapping.
// -----------------------------------------------------------------------------
package frame_sequencer_pkg;

    localparam int ANI_W   = 6;
    localparam int FRAME_W = 6;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // A limit of zero would leave no legal frame, so it behaves like a
    // one-frame animation: frame stays 0 and every tick is a wrap.
    function automatic logic [FRAME_W-1:0] eff_limit(input logic [FRAME_W-1:0] lim);
        return (lim == '0) ? FRAME_W'(1) : lim;
    endfunction

endpackage

// File: rtl/frame_sequencer_tick.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Programmable prescaler producing one frame-advance request every
// max(1, BASE_DIV >> speed) counting cycles.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   ena         global enable; low freezes the counter
//   clear       synchronous clear of the counter (wins over run)
//   run         count enable; low holds the current count
//   speed       divisor shift amount
//   tick        combinational: high in the cycle the counter hits its last
//               value while running; the counter returns to 0 on that edge
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int BASE_DIV = 10_000_000,
    parameter int PRESC_W  = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       clear,
    input  logic       run,
    input  logic [2:0] speed,
    output logic       tick
);

    // One extra bit so BASE_DIV == 2**PRESC_W still shifts correctly.
    localparam logic [PRESC_W:0] BASE = (PRESC_W+1)'(BASE_DIV);

    logic [PRESC_W:0]   shifted;
    logic [PRESC_W-1:0] divisor;
    logic [PRESC_W-1:0] last;
    logic [PRESC_W-1:0] count;
    logic               terminal;

    // Divisor floors at 1 so the fastest speeds tick every cycle. A divisor
    // of exactly 2**PRESC_W truncates to 0, whose "last" value is all ones,
    // which still gives the right period.
    always_comb begin
        shifted = BASE >> speed;
        if (shifted == '0) begin
            divisor = PRESC_W'(1);
        end else begin
            divisor = shifted[PRESC_W-1:0];
        end
        last = divisor - PRESC_W'(1);
    end

    // >= rather than == so a speed change that shrinks the divisor below the
    // current count still terminates on the next counting cycle.
    assign terminal = (count >= last);
    assign tick     = ena && run && !clear && terminal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (ena) begin
            if (clear) begin
                count <= '0;
            end else if (run) begin
                count <= terminal ? '0 : count + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// Timing and frame-stepping stage in front of the frame-limit lookup and the
// segment pattern ROM. It owns the current animation index, takes back that
// animation's frame count, and steps a frame counter from a prescaler,
// optionally moving to the next animation after LOOPS complete loops.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   ena            design enable; low freezes all state, pulses go low
//   animation_sel  requested animation in manual mode
//   limit          frame count of the current animation (lookup result)
//   speed          prescaler divisor = max(1, BASE_DIV >> speed)
//   auto_mode      1 = auto-advance, 0 = follow animation_sel
//   pause          1 = hold current frame
//   animation      registered current animation index
//   frame          registered frame index, 0..limit-1
//   frame_tick     one-cycle pulse on each frame advance
//   loop_done      one-cycle pulse when frame wraps to 0
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int BASE_DIV = 10_000_000,
    parameter int PRESC_W  = 24,
    parameter int LOOPS    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [5:0] animation_sel,
    input  logic [5:0] limit,
    input  logic [2:0] speed,
    input  logic       auto_mode,
    input  logic       pause,
    output logic [5:0] animation,
    output logic [5:0] frame,
    output logic       frame_tick,
    output logic       loop_done
);

    import frame_sequencer_pkg::*;

    localparam int LOOP_W = $clog2(LOOPS + 1);

    state_t              state;
    logic [LOOP_W-1:0]   loop_cnt;
    logic [FRAME_W-1:0]  lim_eff;
    logic                manual_change;
    logic                wrap;
    logic                last_loop;
    logic                presc_clear;
    logic                presc_run;
    logic                presc_tick;

    assign manual_change = !auto_mode && (animation_sel != animation);
    assign lim_eff       = eff_limit(limit);
    // >= catches an external limit drop below the current frame.
    assign wrap          = (frame >= lim_eff - FRAME_W'(1));
    assign last_loop     = (loop_cnt >= LOOP_W'(LOOPS - 1));

    // The prescaler only counts in a running cycle that is not about to be
    // paused or replaced by an animation change, so those cycles keep the
    // count for later resumption.
    assign presc_clear = (state == S_LOAD);
    assign presc_run   = (state == S_RUN) && !pause && !manual_change;

    tick_prescaler #(
        .BASE_DIV (BASE_DIV),
        .PRESC_W  (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clear (presc_clear),
        .run   (presc_run),
        .speed (speed),
        .tick  (presc_tick)
    );

    // Sequencer FSM with all outputs registered. An animation change always
    // wins over a simultaneous tick: the tick is dropped and no pulse fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_LOAD;
            animation  <= '0;
            frame      <= '0;
            loop_cnt   <= '0;
            frame_tick <= 1'b0;
            loop_done  <= 1'b0;
        end else if (!ena) begin
            frame_tick <= 1'b0;
            loop_done  <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            loop_done  <= 1'b0;
            case (state)
                S_LOAD: begin
                    frame    <= '0;
                    loop_cnt <= '0;
                    state    <= pause ? S_HOLD : S_RUN;
                end
                S_RUN: begin
                    if (manual_change) begin
                        animation <= animation_sel;
                        frame     <= '0;
                        state     <= S_LOAD;
                    end else if (pause) begin
                        state <= S_HOLD;
                    end else if (presc_tick) begin
                        if (!wrap) begin
                            frame      <= frame + FRAME_W'(1);
                            frame_tick <= 1'b1;
                        end else if (auto_mode && last_loop) begin
                            animation <= animation + ANI_W'(1);
                            frame     <= '0;
                            state     <= S_LOAD;
                        end else begin
                            frame      <= '0;
                            frame_tick <= 1'b1;
                            loop_done  <= 1'b1;
                            if (auto_mode) begin
                                loop_cnt <= loop_cnt + LOOP_W'(1);
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (manual_change) begin
                        animation <= animation_sel;
                        frame     <= '0;
                        state     <= S_LOAD;
                    end else if (!pause) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule
